// File: rtl/lpm_table_access_ctrl.sv
// Serialises host register reads/writes and a full-table clear onto the ip_lpm route
// table ports, one outstanding operation at a time, with an ack watchdog per operation.
module lpm_table_access_ctrl #(
    parameter int NUM_QUEUES     = 5,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
    parameter int TIMEOUT        = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      host_rd_req,
    input  logic [LUT_DEPTH_BITS-1:0] host_rd_addr,
    output logic [31:0]               host_rd_ip,
    output logic [31:0]               host_rd_mask,
    output logic [NUM_QUEUES-1:0]     host_rd_oq,
    output logic [31:0]               host_rd_next_hop_ip,
    output logic                      host_rd_ack,
    input  logic                      host_wr_req,
    input  logic [LUT_DEPTH_BITS-1:0] host_wr_addr,
    input  logic [31:0]               host_wr_ip,
    input  logic [31:0]               host_wr_mask,
    input  logic [NUM_QUEUES-1:0]     host_wr_oq,
    input  logic [31:0]               host_wr_next_hop_ip,
    output logic                      host_wr_ack,
    output logic                      host_err,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      lpm_rd_req,
    output logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr,
    input  logic [31:0]               lpm_rd_ip,
    input  logic [31:0]               lpm_rd_mask,
    input  logic [31:0]               lpm_rd_next_hop_ip,
    input  logic [NUM_QUEUES-1:0]     lpm_rd_oq,
    input  logic                      lpm_rd_ack,
    output logic                      lpm_wr_req,
    output logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr,
    output logic [31:0]               lpm_wr_ip,
    output logic [31:0]               lpm_wr_mask,
    output logic [31:0]               lpm_wr_next_hop_ip,
    output logic [NUM_QUEUES-1:0]     lpm_wr_oq,
    input  logic                      lpm_wr_ack
);
    // state    | meaning
    // IDLE     | arbitrate: pending clear > host write > host read
    // RD_WAIT  | host read issued; waiting for table ack, then one cycle to present host ack
    // WR_WAIT  | host write issued; waiting for table ack
    // CLR_WR   | drive null route for entry idx
    // CLR_WAIT | waiting for ack of clear write to entry idx
    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, CLR_WR, CLR_WAIT} state_t;

    localparam int CNT_BITS = $clog2(TIMEOUT);
    localparam logic [CNT_BITS-1:0]       CNT_LAST = CNT_BITS'(TIMEOUT - 1);
    localparam logic [LUT_DEPTH_BITS-1:0] IDX_LAST = LUT_DEPTH_BITS'(LUT_DEPTH - 1);

    state_t                    state;
    logic [CNT_BITS-1:0]       cnt;
    logic [LUT_DEPTH_BITS-1:0] idx;
    logic                      rd_fin;
    logic                      rd_err;
    logic                      expired;
    logic                      host_ack_cycle;

    assign expired        = (cnt == CNT_LAST);
    // The host still holds its req while it sees the ack, so no grant in that cycle.
    assign host_ack_cycle = host_rd_ack | host_wr_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            idx                 <= '0;
            rd_fin              <= 1'b0;
            rd_err              <= 1'b0;
            host_rd_ip          <= '0;
            host_rd_mask        <= '0;
            host_rd_oq          <= '0;
            host_rd_next_hop_ip <= '0;
            host_rd_ack         <= 1'b0;
            host_wr_ack         <= 1'b0;
            host_err            <= 1'b0;
            clear_busy          <= 1'b0;
            clear_done          <= 1'b0;
            lpm_rd_req          <= 1'b0;
            lpm_rd_addr         <= '0;
            lpm_wr_req          <= 1'b0;
            lpm_wr_addr         <= '0;
            lpm_wr_ip           <= '0;
            lpm_wr_mask         <= '0;
            lpm_wr_next_hop_ip  <= '0;
            lpm_wr_oq           <= '0;
        end else begin
            host_rd_ack <= 1'b0;
            host_wr_ack <= 1'b0;
            host_err    <= 1'b0;
            clear_done  <= 1'b0;
            if (clear_start && !clear_busy) clear_busy <= 1'b1;

            case (state)
                IDLE: begin
                    if (clear_busy) begin
                        state <= CLR_WR;
                    end else if (host_wr_req && !host_ack_cycle) begin
                        lpm_wr_addr        <= host_wr_addr;
                        lpm_wr_ip          <= host_wr_ip;
                        lpm_wr_mask        <= host_wr_mask;
                        lpm_wr_oq          <= host_wr_oq;
                        lpm_wr_next_hop_ip <= host_wr_next_hop_ip;
                        lpm_wr_req         <= 1'b1;
                        cnt                <= '0;
                        state              <= WR_WAIT;
                    end else if (host_rd_req && !host_ack_cycle) begin
                        lpm_rd_addr <= host_rd_addr;
                        lpm_rd_req  <= 1'b1;
                        cnt         <= '0;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_fin) begin
                        rd_fin      <= 1'b0;
                        rd_err      <= 1'b0;
                        host_rd_ack <= 1'b1;
                        host_err    <= rd_err;
                        state       <= IDLE;
                    end else if (lpm_rd_ack) begin
                        host_rd_ip          <= lpm_rd_ip;
                        host_rd_mask        <= lpm_rd_mask;
                        host_rd_oq          <= lpm_rd_oq;
                        host_rd_next_hop_ip <= lpm_rd_next_hop_ip;
                        lpm_rd_req          <= 1'b0;
                        rd_fin              <= 1'b1;
                    end else if (expired) begin
                        host_rd_ip          <= '0;
                        host_rd_mask        <= '0;
                        host_rd_oq          <= '0;
                        host_rd_next_hop_ip <= '0;
                        lpm_rd_req          <= 1'b0;
                        rd_fin              <= 1'b1;
                        rd_err              <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (lpm_wr_ack || expired) begin
                        lpm_wr_req  <= 1'b0;
                        host_wr_ack <= 1'b1;
                        host_err    <= !lpm_wr_ack;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLR_WR: begin
                    lpm_wr_addr        <= idx;
                    lpm_wr_ip          <= '0;
                    lpm_wr_mask        <= '1;
                    lpm_wr_oq          <= '0;
                    lpm_wr_next_hop_ip <= '0;
                    lpm_wr_req         <= 1'b1;
                    cnt                <= '0;
                    state              <= CLR_WAIT;
                end
                CLR_WAIT: begin
                    // A timed-out entry is skipped silently; the walk must always finish.
                    if (lpm_wr_ack || expired) begin
                        lpm_wr_req <= 1'b0;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= CLR_WR;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
